// File: rtl/audio_sample_feeder.sv
// Captures the 7-bit waveform at the codec rate and streams signed 32-bit samples to the DAC path.
// Latency: pop-to-write 1 clock, capture-to-write 2 clocks minimum.
// Backpressure: write held until audio_out_allowed; FIFO absorbs stalls, new samples dropped (sticky overflow) when full.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  // Generic FIFO: push accepted when not full or when a pop happens in the same cycle.
  // Latency: 1 clock push-to-visible at head.
  // Backpressure: push_rdy low only when full and not popping.
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign pop_vld  = (count != '0);
  assign pop_en   = pop_vld && pop_rdy;
  assign push_rdy = (count != (AW+1)'(DEPTH)) || pop_en;
  assign push_en  = push_vld && push_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module audio_sample_feeder #(
  parameter int SAMPLE_DIV = 1042,
  parameter int FIFO_DEPTH = 8,
  parameter int GAIN_SHIFT = 24
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [6:0]                   wave,
  input  logic                         mute,
  input  logic                         audio_out_allowed,
  output logic [31:0]                  left_channel_audio_out,
  output logic [31:0]                  right_channel_audio_out,
  output logic                         write_audio_out,
  output logic                         sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);
  // Sample capture, signed conversion, buffering and DAC write handshake.
  // Latency: capture-to-write 2 clocks minimum, one accepted write per sample.
  // Backpressure: audio_out_allowed low stalls writes; samples dropped with sticky overflow once FIFO full.
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DW-1:0]    div_cnt;
  logic             tick_now;
  logic [7:0]       s8;
  logic [31:0]      ext32;
  logic [31:0]      sample_dat;
  logic             push_rdy;
  logic             pop_vld;
  logic             pop_rdy;
  logic [31:0]      pop_dat;
  logic             load_out;
  logic [31:0]      out_dat;

  assign tick_now = (div_cnt == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= tick_now;
      div_cnt     <= tick_now ? '0 : div_cnt + DW'(1);
    end
  end

  // 64 is mid-scale silence; re-centre to -64..+63 before scaling.
  assign s8         = {1'b0, wave} - 8'd64;
  assign ext32      = {{24{s8[7]}}, s8};
  assign sample_dat = mute ? 32'h0 : (ext32 << GAIN_SHIFT);

  sample_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (tick_now),
    .push_rdy (push_rdy),
    .push_dat (sample_dat),
    .pop_vld  (pop_vld),
    .pop_rdy  (pop_rdy),
    .pop_dat  (pop_dat),
    .count    (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    pop_rdy  = 1'b0;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        pop_rdy = 1'b1;
        if (pop_vld) begin
          load_out = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (audio_out_allowed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      out_dat  <= 32'h0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_out) out_dat <= pop_dat;
      if (tick_now && !push_rdy) overflow <= 1'b1;
    end
  end

  assign write_audio_out         = (state_q == WRITE);
  assign left_channel_audio_out  = out_dat;
  assign right_channel_audio_out = out_dat;
endmodule

// File: tb/tb_audio_sample_feeder.sv
// Bench for audio_sample_feeder: conversion vectors, directed stall/reset corners,
// and randomized traffic against a queue-based reference of the sample stream.
module tb_audio_sample_feeder;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int GAIN  = 24;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  wave = 7'd64;
  logic        mute = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;
  logic        sample_tick;
  logic [2:0]  fifo_count;
  logic        overflow;

  always #5 clock = ~clock;

  audio_sample_feeder #(
    .SAMPLE_DIV (DIV),
    .FIFO_DEPTH (DEPTH),
    .GAIN_SHIFT (GAIN)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .wave                    (wave),
    .mute                    (mute),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .sample_tick             (sample_tick),
    .fifo_count              (fifo_count),
    .overflow                (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] conv(input logic [6:0] w, input logic m);
    int s;
    s = int'(w) - 64;
    if (m) return 32'h0;
    return 32'(s * (1 << GAIN));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: samples every DIV clocks, a DEPTH-deep queue, one sample in flight to the DAC.
  int          m_phase = 0;
  logic [31:0] m_q[$];
  bit          m_busy = 0;
  logic [31:0] m_out = 0;
  bit          m_tick = 0;
  bit          m_ovf = 0;
  logic [31:0] m_acc[$];
  logic [31:0] d_acc[$];

  always @(posedge clock) begin : model
    bit push;
    bit pop;
    int pre;
    if (m_busy && audio_out_allowed) m_acc.push_back(m_out);
    if (reset) begin
      m_phase = 0;
      m_q.delete();
      m_busy  = 0;
      m_out   = 0;
      m_tick  = 0;
      m_ovf   = 0;
    end else begin
      push    = (m_phase == DIV - 1);
      m_tick  = push;
      m_phase = (m_phase + 1) % DIV;
      pre     = m_q.size();
      pop     = !m_busy && pre > 0;
      if (m_busy && audio_out_allowed) m_busy = 0;
      else if (pop) begin
        m_out  = m_q.pop_front();
        m_busy = 1;
      end
      if (push) begin
        if (pre < DEPTH || pop) m_q.push_back(conv(wave, mute));
        else m_ovf = 1;
      end
    end
  end

  // Drive one cycle of inputs, then compare every output with the reference mid-next-cycle.
  task automatic cyc(input logic [6:0] w, input logic m, input logic a, input logic r);
    wave = w;
    mute = m;
    audio_out_allowed = a;
    reset = r;
    if (write_audio_out && audio_out_allowed) d_acc.push_back(left_channel_audio_out);
    @(negedge clock);
    check("write",  32'(write_audio_out), 32'(m_busy));
    check("left",   left_channel_audio_out, m_out);
    check("right",  right_channel_audio_out, m_out);
    check("tick",   32'(sample_tick), 32'(m_tick));
    check("count",  32'(fifo_count), 32'(m_q.size()));
    check("ovf",    32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    cyc(wave, 1'b0, 1'b0, 1'b1);
    check("rst_write", 32'(write_audio_out), 32'h0);
    check("rst_left",  left_channel_audio_out, 32'h0);
    check("rst_tick",  32'(sample_tick), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);
    d_acc.delete();
    m_acc.delete();
  endtask

  task automatic cmp_logs(input string name);
    int n;
    check({name, "_n"}, 32'(d_acc.size()), 32'(m_acc.size()));
    n = (d_acc.size() < m_acc.size()) ? d_acc.size() : m_acc.size();
    for (int i = 0; i < n; i++) check({name, "_val"}, d_acc[i], m_acc[i]);
  endtask

  typedef struct {
    logic [6:0]  wave;
    logic        mute;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ticks;
    int writes;
    bit prev_w;
    bit seen;
    int c;
    int thr;

    vecs[0] = '{7'd127, 1'b0, 32'h3F000000};
    vecs[1] = '{7'd0,   1'b0, 32'hC0000000};
    vecs[2] = '{7'd64,  1'b0, 32'h00000000};
    vecs[3] = '{7'd127, 1'b1, 32'h00000000};
    vecs[4] = '{7'd65,  1'b0, 32'h01000000};
    vecs[5] = '{7'd63,  1'b0, 32'hFF000000};
    vecs[6] = '{7'd1,   1'b0, 32'hC1000000};

    // Conversion vectors
    for (int v = 0; v < 7; v++) begin
      do_reset();
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
        cyc(vecs[v].wave, vecs[v].mute, 1'b1, 1'b0);
        if (write_audio_out) seen = 1;
      end
      check("vec_write_seen", 32'(seen), 32'h1);
      check("vec_left",  left_channel_audio_out, vecs[v].exp);
      check("vec_right", right_channel_audio_out, vecs[v].exp);
    end

    // Free-running at full scale: one tick and one 1-wide write per DIV clocks
    do_reset();
    ticks = 0; writes = 0; prev_w = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(7'd127, 1'b0, 1'b1, 1'b0);
      if (sample_tick) ticks++;
      if (write_audio_out) begin
        writes++;
        check("run_left", left_channel_audio_out, 32'h3F000000);
        check("run_width", 32'(prev_w), 32'h0);
      end
      prev_w = write_audio_out;
    end
    check("run_ticks",  32'(ticks), 32'd4);
    check("run_writes", 32'(writes), 32'd4);

    // Long stall: FIFO fills, overflow sets, then drains in capture order
    do_reset();
    for (c = 0; c < 30; c++) cyc(7'(10 * (c / 4 + 1)), 1'b0, 1'b0, 1'b0);
    check("stall_ovf",   32'(overflow), 32'h1);
    check("stall_count", 32'(fifo_count), 32'd4);
    check("stall_write", 32'(write_audio_out), 32'h1);
    check("stall_left",  left_channel_audio_out, conv(7'd10, 1'b0));
    for (c = 30; c < 60; c++) cyc((c < 32) ? 7'(10 * (c / 4 + 1)) : 7'd100, 1'b0, 1'b1, 1'b0);
    check("stall_nacc", 32'(d_acc.size() >= 5), 32'h1);
    for (int i = 0; i < 5 && i < d_acc.size(); i++)
      check("stall_order", d_acc[i], conv(7'(10 * (i + 1)), 1'b0));
    cmp_logs("stall");

    // Sparse grants: allowed one clock in three
    do_reset();
    for (c = 0; c < 90; c++) cyc(7'($urandom_range(0, 127)), 1'b0, (c % 3) == 0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(7'd64, 1'b0, 1'b1, 1'b0);
    check("sparse_ovf", 32'(overflow), 32'h0);
    cmp_logs("sparse");

    // Reset while a write is pending and two samples are queued
    do_reset();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc(7'd100, 1'b0, 1'b0, 1'b0);
      if (fifo_count == 3'd2) seen = 1;
    end
    check("rstw_reached", 32'(seen), 32'h1);
    check("rstw_pre_write", 32'(write_audio_out), 32'h1);
    cyc(7'd100, 1'b0, 1'b0, 1'b1);
    check("rstw_write", 32'(write_audio_out), 32'h0);
    check("rstw_count", 32'(fifo_count), 32'h0);
    check("rstw_ovf",   32'(overflow), 32'h0);
    check("rstw_left",  left_channel_audio_out, 32'h0);

    // Full FIFO with a pop landing on the capture cycle: no drop
    do_reset();
    seen = 0;
    c = 0;
    while (c < 40 && !seen) begin
      cyc(7'd90, 1'b0, 1'b0, 1'b0);
      c++;
      if (fifo_count == 3'd4) seen = 1;
    end
    check("full_reached", 32'(seen), 32'h1);
    while ((c % DIV) != DIV - 2) begin
      cyc(7'd90, 1'b0, 1'b0, 1'b0);
      c++;
    end
    cyc(7'd90, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(7'd91, 1'b0, 1'b0, 1'b0);
    check("full_ovf",   32'(overflow), 32'h0);
    check("full_count", 32'(fifo_count), 32'd4);

    // Randomized traffic with varying stall density
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      thr = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 100; i++)
        cyc(7'($urandom_range(0, 127)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) < thr, 1'b0);
    end
    for (int i = 0; i < 40; i++) cyc(7'd64, 1'b0, 1'b1, 1'b0);
    cmp_logs("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
